rpn_expr_sequencer: RTL and testbench
=====================================

// Module: rpn_expr_sequencer
// PURPOSE
//  Initiator side of the stack-ALU opcode interface: accepts a postfix (RPN) token stream over a
//  valid/ready handshake and drives opcode/operand into STACK_BASED_ALU, one op per issue slot.
//  Checks stack depth before issue, drains the ALU stack at END, returns the result with an error flag.
// PARAMETERS
//  DATA_WIDTH  8   operand/result width; must match the ALU
//  STACK_SIZE  64  ALU stack depth; depth counter is $clog2(STACK_SIZE+1) bits
// PORTS
//  clk           in   1   single clock; all state on rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  tok_valid     in   1   token present
//  tok_ready     out  1   token accepted when tok_valid&&tok_ready at rising clk
//  tok_kind      in   2   00 NUM, 01 ADD, 10 MUL, 11 END
//  tok_value     in   DW  operand, used only for NUM
//  alu_opcode    out  3   100 add, 101 mul, 110 push, 111 pop, 000 idle
//  alu_data      out  DW  push operand (else 0)
//  alu_output    in   DW  ALU output_data
//  alu_overflow  in   1   ALU overflow flag
//  res_valid     out  1   result available
//  res_ready     in   1   result consumed when res_valid&&res_ready
//  res_data      out  DW  expression result (0 on error)
//  res_error     out  1   expression invalid or arithmetic overflow
// BEHAVIOUR
//  Reset: all outputs 0 (alu_opcode=000, tok_ready=0, res_valid=0); depth=0; err=0; state=INIT.
//  Outputs registered. ALU samples opcode at edge E; alu_output/alu_overflow read at edge E+1.
//  INIT: issue STACK_SIZE pops back-to-back (empties ALU; its overflow ignored), then FETCH.
//  FETCH: tok_ready=1, alu_opcode=000. On handshake, go ISSUE (legal) or REJECT/DRAIN:
//   NUM: legal if depth<STACK_SIZE. ADD/MUL: legal if depth>=2. END: always to DRAIN.
//   Illegal NUM/ADD/MUL: op NOT issued, err<=1 (sticky), stay FETCH (REJECT folded in).
//  ISSUE: drive alu_opcode (one cycle only) and alu_data; depth +1 push, -1 add/mul; go CHECK.
//  CHECK: alu_opcode=000; if add/mul and alu_overflow=1 then err<=1; back to FETCH.
//   Net: 3 cycles per legal token (FETCH, ISSUE, CHECK); tok_ready low in ISSUE/CHECK.
//  DRAIN: if depth==0 then err<=1 and go RESULT. Else issue pop, wait one cycle; on the first pop
//   latch res_data<=alu_output; depth-1 per pop; repeat until depth==0, then RESULT.
//   depth!=1 at END sets err<=1.
//  RESULT: res_valid=1, res_error=err, res_data=err?0:latched; hold stable until res_ready.
//   On handshake: res_valid<=0, err<=0, go FETCH. tok_ready=0 throughout DRAIN/RESULT.
//  Width: depth saturates in range 0..STACK_SIZE by construction; arithmetic wrap lives in the ALU.
//  Reset mid-operation: any state aborts and returns to INIT; partial result is discarded.
//  tok_kind/tok_value ignored unless tok_valid&&tok_ready.
// TESTING
//  1) After reset, 64 pops are issued before tok_ready rises; alu_opcode=111 for exactly 64 cycles.
//  2) NUM 05, NUM 03, ADD, END -> res_data=08, res_error=0; ALU sees 110,110,100,111.
//  3) NUM 02, NUM 03, ADD, NUM 04, MUL, END -> res_data=14h, res_error=0.
//  4) NUM 05, ADD, END -> ADD not issued, res_error=1, res_data=0; one pop drained.
//  5) 65 x NUM 01, END -> 65th push suppressed, 64 pops drained, res_error=1.
//  6) NUM F0, NUM 20, ADD, END with res_ready low 5 cycles -> res_error=1 (overflow); res_valid
//     and res_data hold stable and tok_ready=0; rst_n pulse mid-token -> back to INIT.

Source files
------------

// File: rtl/rpn_expr_sequencer.sv
// -----------------------------------------------------------------------------
// rpn_expr_sequencer
//
// Initiator for a stack-based ALU. A postfix (RPN) token stream arrives on a
// valid/ready handshake. Each legal token becomes exactly one ALU opcode in a
// single issue slot. The sequencer keeps its own copy of the ALU stack depth,
// so an illegal token (push onto a full stack, or add/mul with fewer than two
// operands) is rejected before anything reaches the ALU. It is recorded in a
// sticky error flag. On END the ALU stack is drained with pops. The first pop
// returns the top of stack, which is the expression result. That result is
// then presented on a valid/ready result port together with the error flag.
//
// Ports
//   clk, rst_n            single clock, asynchronous active-low reset
//   tok_valid/tok_ready   token handshake (accept on valid && ready)
//   tok_kind              00 NUM, 01 ADD, 10 MUL, 11 END
//   tok_value             operand for NUM tokens
//   alu_opcode            100 add, 101 mul, 110 push, 111 pop, 000 idle
//   alu_data              push operand (zero otherwise)
//   alu_output            ALU output data, valid one edge after the opcode
//   alu_overflow          ALU overflow flag, valid one edge after the opcode
//   res_valid/res_ready   result handshake
//   res_data              expression result (zero when res_error is set)
//   res_error             invalid expression or arithmetic overflow
//
// All outputs are registered. The ALU samples alu_opcode at edge E, and its
// alu_output/alu_overflow are read back at edge E+1. Every legal token
// therefore takes three cycles: FETCH (handshake), ISSUE (opcode on the bus)
// and CHECK (read the overflow flag).
// -----------------------------------------------------------------------------
module rpn_expr_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int STACK_SIZE = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tok_valid,
  output logic                  tok_ready,
  input  logic [1:0]            tok_kind,
  input  logic [DATA_WIDTH-1:0] tok_value,
  output logic [2:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_data,
  input  logic [DATA_WIDTH-1:0] alu_output,
  input  logic                  alu_overflow,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_error
);

  localparam int DEPTH_W = $clog2(STACK_SIZE + 1);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_SIZE);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_TWO = DEPTH_W'(2);

  localparam logic [2:0] OP_IDLE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] TK_NUM = 2'b00;
  localparam logic [1:0] TK_ADD = 2'b01;
  localparam logic [1:0] TK_MUL = 2'b10;
  localparam logic [1:0] TK_END = 2'b11;

  // S_DRAIN decides whether another pop is needed. S_DPOP holds the pop on
  // the bus. S_DWAIT is the cycle in which the popped value is readable.
  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_ISSUE,
    S_CHECK,
    S_DRAIN,
    S_DPOP,
    S_DWAIT,
    S_RESULT
  } state_e;

  state_e                state_q,     state_d;
  logic [DEPTH_W-1:0]    depth_q,     depth_d;
  logic [DEPTH_W-1:0]    init_cnt_q,  init_cnt_d;
  logic                  err_q,       err_d;
  logic                  arith_q,     arith_d;
  logic                  first_pop_q, first_pop_d;
  logic [DATA_WIDTH-1:0] result_q,    result_d;
  logic                  tok_ready_q, tok_ready_d;
  logic [2:0]            alu_opcode_q, alu_opcode_d;
  logic [DATA_WIDTH-1:0] alu_data_q,  alu_data_d;
  logic                  res_valid_q, res_valid_d;
  logic [DATA_WIDTH-1:0] res_data_q,  res_data_d;
  logic                  res_error_q, res_error_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      depth_q      <= '0;
      init_cnt_q   <= '0;
      err_q        <= 1'b0;
      arith_q      <= 1'b0;
      first_pop_q  <= 1'b0;
      result_q     <= '0;
      tok_ready_q  <= 1'b0;
      alu_opcode_q <= OP_IDLE;
      alu_data_q   <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      init_cnt_q   <= init_cnt_d;
      err_q        <= err_d;
      arith_q      <= arith_d;
      first_pop_q  <= first_pop_d;
      result_q     <= result_d;
      tok_ready_q  <= tok_ready_d;
      alu_opcode_q <= alu_opcode_d;
      alu_data_q   <= alu_data_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_error_q  <= res_error_d;
    end
  end

  // The registered outputs are computed one cycle ahead. Each _d value is the
  // value the output must carry while the FSM sits in state_d. The opcode and
  // push data default to idle/zero, so any issue lasts exactly one cycle.
  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    init_cnt_d   = init_cnt_q;
    err_d        = err_q;
    arith_d      = arith_q;
    first_pop_d  = first_pop_q;
    result_d     = result_q;
    tok_ready_d  = tok_ready_q;
    alu_opcode_d = OP_IDLE;
    alu_data_d   = '0;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_error_d  = res_error_q;

    unique case (state_q)
      // The ALU stack contents are unknown after reset. STACK_SIZE pops empty
      // it whatever it held. The overflow flag is not looked at here.
      S_INIT: begin
        depth_d = '0;
        if (init_cnt_q != DEPTH_MAX) begin
          alu_opcode_d = OP_POP;
          init_cnt_d   = init_cnt_q + 1'b1;
        end else begin
          init_cnt_d  = '0;
          state_d     = S_FETCH;
          tok_ready_d = 1'b1;
        end
      end

      // An illegal NUM/ADD/MUL is consumed without reaching the ALU. It only
      // marks the expression as bad, and tok_ready stays high.
      S_FETCH: begin
        if (tok_valid && tok_ready_q) begin
          unique case (tok_kind)
            TK_NUM: begin
              if (depth_q != DEPTH_MAX) begin
                alu_opcode_d = OP_PUSH;
                alu_data_d   = tok_value;
                state_d      = S_ISSUE;
                tok_ready_d  = 1'b0;
              end else begin
                err_d = 1'b1;
              end
            end
            TK_ADD, TK_MUL: begin
              if (depth_q >= DEPTH_TWO) begin
                alu_opcode_d = (tok_kind == TK_ADD) ? OP_ADD : OP_MUL;
                state_d      = S_ISSUE;
                tok_ready_d  = 1'b0;
              end else begin
                err_d = 1'b1;
              end
            end
            TK_END: begin
              // A well-formed expression leaves exactly one value on the stack.
              if (depth_q != DEPTH_ONE) err_d = 1'b1;
              first_pop_d = 1'b1;
              state_d     = S_DRAIN;
              tok_ready_d = 1'b0;
            end
            default: ;
          endcase
        end
      end

      S_ISSUE: begin
        if (alu_opcode_q == OP_PUSH) begin
          depth_d = depth_q + 1'b1;
          arith_d = 1'b0;
        end else begin
          depth_d = depth_q - 1'b1;
          arith_d = 1'b1;
        end
        state_d = S_CHECK;
      end

      // This is edge E+1 for the opcode issued in S_ISSUE.
      S_CHECK: begin
        if (arith_q && alu_overflow) err_d = 1'b1;
        state_d     = S_FETCH;
        tok_ready_d = 1'b1;
      end

      S_DRAIN: begin
        if (depth_q == '0) begin
          state_d     = S_RESULT;
          res_valid_d = 1'b1;
          res_error_d = err_q;
          res_data_d  = err_q ? '0 : result_q;
        end else begin
          alu_opcode_d = OP_POP;
          state_d      = S_DPOP;
        end
      end

      S_DPOP: begin
        depth_d = depth_q - 1'b1;
        state_d = S_DWAIT;
      end

      // Only the first pop returns the expression result (top of stack). Any
      // further pops clear leftovers from a malformed expression.
      S_DWAIT: begin
        if (first_pop_q) begin
          result_d    = alu_output;
          first_pop_d = 1'b0;
        end
        state_d = S_DRAIN;
      end

      S_RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_data_d  = '0;
          res_error_d = 1'b0;
          err_d       = 1'b0;
          result_d    = '0;
          state_d     = S_FETCH;
          tok_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign tok_ready  = tok_ready_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_data   = alu_data_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_error  = res_error_q;

endmodule

// File: tb/tb_rpn_expr_sequencer.sv
`timescale 1ns/1ps
module tb_rpn_expr_sequencer;

  localparam int DW = 8;
  localparam int SS = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic [1:0]    tok_kind = 2'b00;
  logic [DW-1:0] tok_value = '0;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_data;
  logic [DW-1:0] alu_output = '0;
  logic          alu_overflow = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_error;

  always #5 clk = ~clk;

  rpn_expr_sequencer #(.DATA_WIDTH(DW), .STACK_SIZE(SS)) dut (
    .clk(clk), .rst_n(rst_n),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_kind(tok_kind), .tok_value(tok_value),
    .alu_opcode(alu_opcode), .alu_data(alu_data),
    .alu_output(alu_output), .alu_overflow(alu_overflow),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_error(res_error)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural stack ALU ----------------
  logic [DW-1:0] alu_stk[$];
  logic [2:0]    alu_log[$];
  logic [15:0]   alu_wide;
  logic [DW-1:0] alu_a, alu_b;

  always @(posedge clk) begin
    if (alu_opcode != 3'b000) alu_log.push_back(alu_opcode);
    case (alu_opcode)
      3'b110: begin
        alu_stk.push_back(alu_data);
        alu_output   <= alu_data;
        alu_overflow <= 1'b0;
      end
      3'b100, 3'b101: begin
        if (alu_stk.size() >= 2) begin
          alu_a = alu_stk.pop_back();
          alu_b = alu_stk.pop_back();
          alu_wide = (alu_opcode == 3'b100) ? ({8'h00, alu_a} + {8'h00, alu_b})
                                            : ({8'h00, alu_a} * {8'h00, alu_b});
          alu_stk.push_back(alu_wide[7:0]);
          alu_output   <= alu_wide[7:0];
          alu_overflow <= (alu_wide > 16'd255);
        end else begin
          alu_output   <= '0;
          alu_overflow <= 1'b1;
        end
      end
      3'b111: begin
        if (alu_stk.size() > 0) alu_output <= alu_stk.pop_back();
        else                    alu_output <= '0;
        alu_overflow <= 1'b0;
      end
      default: ;
    endcase
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int   m_stk[$];
  bit   m_err = 1'b0;

  task automatic model_tok(input logic [1:0] k, input logic [DW-1:0] v);
    int a, b, r;
    exp_t e;
    case (k)
      2'b00: if (m_stk.size() < SS) m_stk.push_back(int'(v)); else m_err = 1'b1;
      2'b01, 2'b10: begin
        if (m_stk.size() >= 2) begin
          a = m_stk.pop_back();
          b = m_stk.pop_back();
          r = (k == 2'b01) ? a + b : a * b;
          if (r > 255) m_err = 1'b1;
          m_stk.push_back(r % 256);
        end else begin
          m_err = 1'b1;
        end
      end
      default: begin
        if (m_stk.size() != 1) m_err = 1'b1;
        e.err  = m_err;
        e.data = (m_err || m_stk.size() == 0) ? 8'h00 : 8'(m_stk[m_stk.size()-1]);
        sb.push_back(e);
        m_stk.delete();
        m_err = 1'b0;
      end
    endcase
  endtask

  // ---------------- result monitor ----------------
  bit            hold = 1'b0;
  bit            last_v = 1'b0;
  logic [DW-1:0] last_data;
  logic          last_err;
  exp_t          e_mon;

  always @(negedge clk) begin
    if (!rst_n) begin
      res_ready = 1'b0;
      last_v    = 1'b0;
    end else if (res_valid) begin
      if (last_v) begin
        chk("res_data_stable", res_data, last_data);
        chk("res_error_stable", res_error, last_err);
      end
      chk("tok_ready_low_in_result", tok_ready, 1'b0);
      if (!hold && $urandom_range(0, 2) == 0) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got data %0h err %0b, expected none", res_data, res_error);
        end else begin
          e_mon = sb.pop_front();
          chk("res_data", res_data, e_mon.data);
          chk("res_error", res_error, e_mon.err);
        end
        res_ready = 1'b1;
        last_v    = 1'b0;
      end else begin
        res_ready = 1'b0;
        last_v    = 1'b1;
        last_data = res_data;
        last_err  = res_error;
      end
    end else begin
      res_ready = 1'b0;
      last_v    = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_tok(input logic [1:0] k, input logic [DW-1:0] v);
    int n;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      tok_kind  = 2'($urandom);
      tok_value = 8'($urandom);
    end
    @(negedge clk);
    tok_valid = 1'b1;
    tok_kind  = k;
    tok_value = v;
    n = 0;
    while (!tok_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!tok_ready) begin
      chk("tok_accept_timeout", 32'd1, 32'd0);
      tok_valid = 1'b0;
      return;
    end
    model_tok(k, v);
    @(posedge clk);
    #1;
    tok_valid = 1'b0;
    tok_kind  = 2'($urandom);
    tok_value = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || res_valid) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", n >= 5000, 1'b0);
    @(negedge clk);
  endtask

  task automatic run_reset();
    int pops, cyc;
    rst_n = 1'b0;
    tok_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tok_ready", tok_ready, 1'b0);
    chk("rst_alu_opcode", alu_opcode, 3'b000);
    chk("rst_alu_data", alu_data, '0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, '0);
    chk("rst_res_error", res_error, 1'b0);
    m_stk.delete();
    m_err = 1'b0;
    sb.delete();
    rst_n = 1'b1;
    pops = 0;
    cyc  = 0;
    while (!tok_ready && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (alu_opcode == 3'b111) pops++;
    end
    chk("init_pop_count", pops, SS);
    chk("init_tok_ready", tok_ready, 1'b1);
    chk("init_opcode_idle", alu_opcode, 3'b000);
  endtask

  task automatic chk_log(input string name, input logic [11:0] ops, input int n);
    logic [11:0] o;
    o = ops;
    chk({name, "_count"}, alu_log.size(), n);
    for (int i = 0; i < n && i < alu_log.size(); i++)
      chk({name, "_op"}, alu_log[i], o[3*(n-1-i) +: 3]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    run_reset();

    // NUM 05, NUM 03, ADD, END
    alu_log.delete();
    send_tok(2'b00, 8'h05); send_tok(2'b00, 8'h03); send_tok(2'b01, 8'h00); send_tok(2'b11, 8'h00);
    wait_idle();
    chk_log("t2_alu", {3'b110, 3'b110, 3'b100, 3'b111}, 4);

    // (2+3)*4
    send_tok(2'b00, 8'h02); send_tok(2'b00, 8'h03); send_tok(2'b01, 8'h00);
    send_tok(2'b00, 8'h04); send_tok(2'b10, 8'h00); send_tok(2'b11, 8'h00);
    wait_idle();

    // ADD with one operand is suppressed
    alu_log.delete();
    send_tok(2'b00, 8'h05); send_tok(2'b01, 8'h00); send_tok(2'b11, 8'h00);
    wait_idle();
    chk_log("t4_alu", {6'b000000, 3'b110, 3'b111}, 2);

    // END on an empty stack
    send_tok(2'b11, 8'h00);
    wait_idle();

    // 65 pushes: the last is suppressed, 64 pops drained
    alu_log.delete();
    for (int i = 0; i < SS + 1; i++) send_tok(2'b00, 8'h01);
    send_tok(2'b11, 8'h00);
    wait_idle();
    chk("t5_alu_count", alu_log.size(), 2 * SS);

    // randomized expressions
    for (int x = 0; x < 40; x++) begin
      int len;
      len = $urandom_range(1, 9);
      for (int t = 0; t < len; t++) begin
        logic [1:0] k;
        logic [DW-1:0] v;
        k = ($urandom_range(0, 9) < 5) ? 2'b00 : ($urandom_range(0, 1) ? 2'b01 : 2'b10);
        v = $urandom_range(0, 1) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        send_tok(k, v);
      end
      send_tok(2'b11, 8'h00);
    end
    wait_idle();

    // overflow with result backpressure
    hold = 1'b1;
    send_tok(2'b00, 8'hF0); send_tok(2'b00, 8'h20); send_tok(2'b01, 8'h00); send_tok(2'b11, 8'h00);
    begin
      int n;
      n = 0;
      while (!res_valid && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("t6_res_valid_seen", res_valid, 1'b1);
    end
    repeat (5) @(negedge clk);
    hold = 1'b0;
    wait_idle();

    // reset in the middle of an expression
    send_tok(2'b00, 8'h07);
    @(negedge clk);
    tok_valid = 1'b1;
    tok_kind  = 2'b00;
    tok_value = 8'h09;
    begin
      int n;
      n = 0;
      while (!tok_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    @(posedge clk);
    #2;
    run_reset();
    send_tok(2'b00, 8'h09); send_tok(2'b11, 8'h00);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
